cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run controller for the single-cycle ISA core. It sits between the `Top` bench and the core. It holds the core in reset until `start` is pulsed, loads the program-start PC, and gates instruction execution via `core_en`. Execution can be free-running or single-step. The block detects halt or timeout, reports `done`, and counts executed cycles.

## Interface
- `PC_W`, default 10: width of the program counter and start address.
- `CYC_W`, default 16: width of the executed-cycle counter.
- `TIMEOUT`, default 100: maximum number of executed cycles before forced stop. A value of 0 disables the timeout.

Ports:
- `clk` input 1: system clock. Everything is on the rising edge.
- `reset` input 1: one clock domain, synchronous and active-high.
- `start` input 1: single-cycle pulse that begins a run. Accepted only in IDLE or DONE.
- `abort` input 1: returns to IDLE from any state. Has priority over every other input.
- `step_mode` input 1: sampled in INIT. 1 selects single-step, 0 selects free run.
- `step_req` input 1: single-cycle pulse that executes one instruction. Used only in STEP_WAIT.
- `start_addr` input PC_W: program entry PC, latched on an accepted `start`.
- `halt_in` input 1: from the core decode stage; the current instruction is a halt.
- `core_rst` output 1: held-reset for the core.
- `pc_load` output 1: the core PC loads `pc_load_val` this cycle.
- `pc_load_val` output PC_W: the latched `start_addr`.
- `core_en` output 1: the core commits the current instruction this cycle.
- `busy` output 1: high in INIT, RUN, STEP_WAIT and STEP_EXEC.
- `done` output 1: high in DONE.
- `timed_out` output 1: valid while `done` is high. 1 means the run ended on timeout.
- `cycle_cnt` output CYC_W: number of cycles in which `core_en` was high during the current or last run.

## Operation
All outputs are registered or decoded from registered state; none are combinational from inputs.

States:
- **IDLE**
  - Outputs: `core_rst`=1, `core_en`=0, `busy`=0, `done`=0.
  - `start` → INIT. `start_addr` is latched into `pc_load_val`.
- **INIT** (exactly 1 cycle)
  - Outputs: `core_rst`=0, `pc_load`=1, `core_en`=0. `cycle_cnt` and `timed_out` clear to 0.
  - Next state: STEP_WAIT if `step_mode`=1, otherwise RUN.
- **RUN**
  - `core_en`=1 and `cycle_cnt` increments every cycle.
  - `halt_in`=1 → DONE with `timed_out`=0.
  - Else, if `TIMEOUT`≠0 and `cycle_cnt`==`TIMEOUT`-1 → DONE with `timed_out`=1.
- **STEP_WAIT**
  - `core_en`=0. `step_req` → STEP_EXEC.
- **STEP_EXEC** (1 cycle)
  - `core_en`=1 and `cycle_cnt` increments.
  - Next state uses the same halt/timeout checks as RUN; otherwise → STEP_WAIT.
- **DONE**
  - Outputs: `done`=1, `core_en`=0, `core_rst`=0. The core state is preserved for inspection. `cycle_cnt` and `timed_out` hold.
  - `start` → INIT, latching a new `start_addr`.

Boundary and priority rules:
- `abort` from any state → IDLE next cycle. `cycle_cnt` holds its value and `timed_out` clears.
- `halt_in` and the timeout condition in the same cycle: halt wins, so `timed_out`=0.
- `start` in INIT, RUN, STEP_WAIT or STEP_EXEC is ignored. `step_req` outside STEP_WAIT is ignored.
- `halt_in` is ignored when `core_en`=0.
- With `TIMEOUT`=0, `cycle_cnt` saturates at all-ones and does not wrap.
- Reset asserted mid-run: the next state is IDLE, and all outputs take their reset values on the following edge.

## Timing
Reset values:
- State: IDLE.
- `core_rst`=1, `pc_load`=0, `pc_load_val`=0, `core_en`=0, `busy`=0, `done`=0, `timed_out`=0, `cycle_cnt`=0.

Latencies:
- `start` high at edge n: INIT (`pc_load`=1) during cycle n+1, and the first `core_en`=1 in cycle n+2 (free run).
- `halt_in`=1 with `core_en`=1 in cycle k: the halting instruction commits in k, and `done`=1 from cycle k+1. `cycle_cnt` includes cycle k.
- Timeout: exactly `TIMEOUT` cycles have `core_en`=1, and `done`=1 on the next cycle.
- `step_req` at edge m: `core_en`=1 in cycle m+1 only.
- `abort` sampled at edge a: `core_rst`=1 in cycle a+1.

## Test plan
1. Free run with a halt:
   - Stimulus: reset, then `start` with `start_addr`=0x010 and `step_mode`=0; `halt_in` asserted on the 7th `core_en` cycle.
   - Required: `pc_load`=1 with value 0x010 one cycle after `start`; `done`=1 with `cycle_cnt`=7 and `timed_out`=0.
2. Timeout:
   - Stimulus: `TIMEOUT`=100, `halt_in` never asserted.
   - Required: exactly 100 `core_en` cycles, then `done`=1, `timed_out`=1, `cycle_cnt`=100.
3. Single step:
   - Stimulus: `step_mode`=1; pulse `step_req` three times with gaps of 4 idle cycles; `halt_in` on the 3rd step.
   - Required: `core_en` is high for exactly 3 isolated cycles, then `done`=1 with `cycle_cnt`=3.
4. Simultaneous halt and timeout:
   - Stimulus: `TIMEOUT`=5, `halt_in` on the 5th `core_en` cycle.
   - Required: `done`=1, `timed_out`=0, `cycle_cnt`=5.
5. Abort mid-run:
   - Stimulus: `abort` at the 3rd RUN cycle.
   - Required: next cycle `core_rst`=1, `core_en`=0, `busy`=0, `cycle_cnt`=3.
   - Follow-up: `start` with `start_addr`=0x020 runs cleanly from 0x020.
6. Reset mid-run and ignored starts:
   - Stimulus: `reset` asserted during STEP_WAIT.
   - Required: all outputs take their reset values on the next edge.
   - Also: `start` pulses during RUN do not reload the PC or clear `cycle_cnt`.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle core: holds the core in reset, loads the entry PC,
// gates commits (free run or single step) and stops on halt, timeout or abort.
module cpu_run_ctrl #(
  parameter int PC_W    = 10,
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             halt_in,
  output logic             core_rst,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_val,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INIT      = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_STEP_WAIT = 3'd3;
  localparam logic [2:0] S_STEP_EXEC = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CYC_W-1:0] TIMEOUT_M1 = CYC_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  logic exec;
  logic halt_hit;
  logic timeout_hit;
  logic cnt_sat;

  // start and step_req are single-cycle pulses with no ready: a pulse that arrives
  // in a state that does not accept it is dropped, never queued.
  assign exec        = (state_q == S_RUN) || (state_q == S_STEP_EXEC);
  assign halt_hit    = exec && halt_in;
  assign timeout_hit = exec && TIMEOUT_EN && (cnt_q == TIMEOUT_M1);
  assign cnt_sat     = &cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    to_d    = to_q;

    // Every committed instruction is counted, including the one committing under abort.
    if (exec && !cnt_sat) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_INIT;
          pc_d    = start_addr;
          cnt_d   = '0;
          to_d    = 1'b0;
        end
      end
      S_INIT: begin
        state_d = step_mode ? S_STEP_WAIT : S_RUN;
      end
      S_RUN: begin
        if (halt_hit) begin
          state_d = S_DONE;
          to_d    = 1'b0;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end
      end
      S_STEP_WAIT: begin
        if (step_req) begin
          state_d = S_STEP_EXEC;
        end
      end
      S_STEP_EXEC: begin
        if (halt_hit) begin
          state_d = S_DONE;
          to_d    = 1'b0;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end else begin
          state_d = S_STEP_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      to_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign core_rst    = (state_q == S_IDLE);
  assign pc_load     = (state_q == S_INIT);
  assign pc_load_val = pc_q;
  assign core_en     = exec;
  assign busy        = (state_q == S_INIT) || (state_q == S_RUN) ||
                       (state_q == S_STEP_WAIT) || (state_q == S_STEP_EXEC);
  assign done        = (state_q == S_DONE);
  assign timed_out   = to_q;
  assign cycle_cnt   = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: default instance plus a TIMEOUT=5 instance and a
// narrow-counter TIMEOUT=0 instance, all driven by the same stimulus.
module tb_cpu_run_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       step_mode;
  logic       step_req;
  logic [9:0] start_addr;
  logic       halt_in;

  logic       a_core_rst, a_pc_load, a_core_en, a_busy, a_done, a_timed_out;
  logic [9:0] a_pc_load_val;
  logic [15:0] a_cycle_cnt;
  logic [2:0] a_dbg_state;

  logic       b_core_rst, b_pc_load, b_core_en, b_busy, b_done, b_timed_out;
  logic [9:0] b_pc_load_val;
  logic [15:0] b_cycle_cnt;
  logic [2:0] b_dbg_state;

  logic       c_core_rst, c_pc_load, c_core_en, c_busy, c_done, c_timed_out;
  logic [9:0] c_pc_load_val;
  logic [3:0] c_cycle_cnt;
  logic [2:0] c_dbg_state;

  int passes;
  int total;
  int n;
  int en_seen;

  cpu_run_ctrl #(.PC_W(10), .CYC_W(16), .TIMEOUT(100)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .step_mode(step_mode),
    .step_req(step_req), .start_addr(start_addr), .halt_in(halt_in),
    .core_rst(a_core_rst), .pc_load(a_pc_load), .pc_load_val(a_pc_load_val),
    .core_en(a_core_en), .busy(a_busy), .done(a_done), .timed_out(a_timed_out),
    .cycle_cnt(a_cycle_cnt), .dbg_state(a_dbg_state)
  );

  cpu_run_ctrl #(.PC_W(10), .CYC_W(16), .TIMEOUT(5)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .step_mode(step_mode),
    .step_req(step_req), .start_addr(start_addr), .halt_in(halt_in),
    .core_rst(b_core_rst), .pc_load(b_pc_load), .pc_load_val(b_pc_load_val),
    .core_en(b_core_en), .busy(b_busy), .done(b_done), .timed_out(b_timed_out),
    .cycle_cnt(b_cycle_cnt), .dbg_state(b_dbg_state)
  );

  cpu_run_ctrl #(.PC_W(10), .CYC_W(4), .TIMEOUT(0)) dut_c (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .step_mode(step_mode),
    .step_req(step_req), .start_addr(start_addr), .halt_in(halt_in),
    .core_rst(c_core_rst), .pc_load(c_pc_load), .pc_load_val(c_pc_load_val),
    .core_en(c_core_en), .busy(c_busy), .done(c_done), .timed_out(c_timed_out),
    .cycle_cnt(c_cycle_cnt), .dbg_state(c_dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    passes     = 0;
    total      = 0;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    step_mode  = 1'b0;
    step_req   = 1'b0;
    start_addr = '0;
    halt_in    = 1'b0;
    tick();
    tick();

    chk("rst_core_rst", a_core_rst, 1);
    chk("rst_pc_load", a_pc_load, 0);
    chk("rst_pc_val", a_pc_load_val, 0);
    chk("rst_core_en", a_core_en, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_timed_out", a_timed_out, 0);
    chk("rst_cnt", a_cycle_cnt, 0);
    reset = 1'b0;

    // Free run, halt on the 7th committed instruction
    start = 1'b1; start_addr = 10'h010;
    tick();
    start = 1'b0;
    chk("t1_pc_load", a_pc_load, 1);
    chk("t1_pc_val", a_pc_load_val, 32'h010);
    chk("t1_init_en", a_core_en, 0);
    chk("t1_init_rst", a_core_rst, 0);
    chk("t1_init_busy", a_busy, 1);
    tick();
    for (int i = 1; i <= 7; i++) begin
      chk("t1_run_en", a_core_en, 1);
      halt_in = (i == 7);
      tick();
    end
    halt_in = 1'b0;
    chk("t1_done", a_done, 1);
    chk("t1_cnt", a_cycle_cnt, 7);
    chk("t1_timed_out", a_timed_out, 0);
    chk("t1_done_en", a_core_en, 0);
    chk("t1_done_rst", a_core_rst, 0);

    // Timeout at 100 on the default instance, at 5 on the second
    start = 1'b1; start_addr = 10'h100;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && a_done !== 1'b1; i++) begin
      if (a_core_en) n++;
      tick();
    end
    chk("t2_en_cycles", n, 100);
    chk("t2_done", a_done, 1);
    chk("t2_timed_out", a_timed_out, 1);
    chk("t2_cnt", a_cycle_cnt, 100);
    chk("t2_b_done", b_done, 1);
    chk("t2_b_timed_out", b_timed_out, 1);
    chk("t2_b_cnt", b_cycle_cnt, 5);
    start = 1'b1; start_addr = 10'h1F0;
    tick();
    start = 1'b0;
    chk("t2_restart_to", a_timed_out, 0);
    chk("t2_restart_cnt", a_cycle_cnt, 0);
    chk("t2_restart_pc", a_pc_load_val, 32'h1F0);
    pulse_abort();
    chk("t2_abort_rst", a_core_rst, 1);
    chk("t2_abort_busy", a_busy, 0);

    // Single step: three steps with 4-cycle gaps, halt on the 3rd
    step_mode = 1'b1; start = 1'b1; start_addr = 10'h030;
    tick();
    start = 1'b0;
    tick();
    en_seen = 0;
    for (int s = 1; s <= 3; s++) begin
      for (int j = 0; j < 4; j++) begin
        if (a_core_en) en_seen++;
        halt_in = (s == 1 && j == 1);
        tick();
      end
      halt_in = 1'b0;
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      chk("t3_step_en", a_core_en, 1);
      if (a_core_en) en_seen++;
      halt_in = (s == 3);
      tick();
      halt_in = 1'b0;
    end
    chk("t3_en_total", en_seen, 3);
    chk("t3_done", a_done, 1);
    chk("t3_cnt", a_cycle_cnt, 3);
    chk("t3_timed_out", a_timed_out, 0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("t3_stray_step_done", a_done, 1);
    chk("t3_stray_step_en", a_core_en, 0);

    // Halt and timeout in the same cycle on the TIMEOUT=5 instance
    pulse_abort();
    step_mode = 1'b0; start = 1'b1; start_addr = 10'h000;
    tick();
    start = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      halt_in = (i == 5);
      tick();
    end
    halt_in = 1'b0;
    chk("t4_b_done", b_done, 1);
    chk("t4_b_timed_out", b_timed_out, 0);
    chk("t4_b_cnt", b_cycle_cnt, 5);
    chk("t4_a_cnt", a_cycle_cnt, 5);

    // Abort in the 3rd RUN cycle, then a clean restart from 0x020
    pulse_abort();
    start = 1'b1; start_addr = 10'h040;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_rst", a_core_rst, 1);
    chk("t5_abort_en", a_core_en, 0);
    chk("t5_abort_busy", a_busy, 0);
    chk("t5_abort_cnt", a_cycle_cnt, 3);
    chk("t5_abort_done", a_done, 0);
    start = 1'b1; start_addr = 10'h020;
    tick();
    start = 1'b0;
    chk("t5_re_pc_load", a_pc_load, 1);
    chk("t5_re_pc_val", a_pc_load_val, 32'h020);
    chk("t5_re_cnt", a_cycle_cnt, 0);
    tick();
    chk("t5_re_en", a_core_en, 1);
    tick();
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    chk("t5_re_done", a_done, 1);
    chk("t5_re_cnt_end", a_cycle_cnt, 2);

    // Reset while waiting for a step
    pulse_abort();
    step_mode = 1'b1; start = 1'b1; start_addr = 10'h055;
    tick();
    start = 1'b0;
    tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    chk("t6_wait_busy", a_busy, 1);
    chk("t6_wait_en", a_core_en, 0);
    chk("t6_wait_cnt", a_cycle_cnt, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_core_rst", a_core_rst, 1);
    chk("t6_rst_pc_load", a_pc_load, 0);
    chk("t6_rst_pc_val", a_pc_load_val, 0);
    chk("t6_rst_en", a_core_en, 0);
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_done", a_done, 0);
    chk("t6_rst_to", a_timed_out, 0);
    chk("t6_rst_cnt", a_cycle_cnt, 0);

    // start during RUN is ignored
    step_mode = 1'b0; start = 1'b1; start_addr = 10'h0AA;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; start_addr = 10'h3FF;
    tick();
    start = 1'b0;
    chk("t6_ign_pc_load", a_pc_load, 0);
    chk("t6_ign_pc_val", a_pc_load_val, 32'h0AA);
    chk("t6_ign_cnt", a_cycle_cnt, 2);
    chk("t6_ign_en", a_core_en, 1);
    chk("t6_ign_busy", a_busy, 1);

    // Counter saturation with the timeout disabled
    pulse_abort();
    start = 1'b1; start_addr = 10'h000;
    tick();
    start = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    chk("t7_c_cnt_sat", c_cycle_cnt, 32'hF);
    chk("t7_c_busy", c_busy, 1);
    chk("t7_c_done", c_done, 0);
    chk("t7_a_cnt", a_cycle_cnt, 20);
    pulse_abort();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
